// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the dmem arbiter and its read-tag pipeline.
// The tag records which requester issued a read so its data can be routed back.
package dmem_arbiter_pkg;

   localparam int DMEM_ADDR_W = 12;
   localparam int DMEM_DATA_W = 32;

   localparam int TAG_CPU = 0;
   localparam int TAG_IO  = 1;

   typedef logic [1:0] rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// DEPTH-stage shift register of 2-bit read tags with asynchronous active-low clear.
// A tag entering on one edge leaves DEPTH edges later, aligned with registered memory data.
module rd_tag_pipe
   import dmem_arbiter_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag
);

   rd_tag_t r_pipe [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port dmem: cpu has priority, io gets a
// bounded-wait override, and read data is routed back by a tag pipeline.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic              io_gnt,
   output logic              io_rvalid,
   output logic [DATA_W-1:0] io_rdata,
   output logic [ADDR_W-1:0] dmem_address,
   output logic [DATA_W-1:0] dmem_data,
   output logic              dmem_wren,
   input  logic [DATA_W-1:0] dmem_q,
   output logic              io_starved
);

   localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

   logic [3:0] r_wait_cnt;
   logic       w_io_starved;
   logic       w_io_win;
   logic       w_cpu_acc;
   logic       w_io_acc;
   rd_tag_t    w_tag_in;
   rd_tag_t    w_tag_out;

   // Grants are gated by reset so nothing reaches dmem while reset is held low.
   always_comb begin
      w_io_starved = (r_wait_cnt == C_MAX_WAIT);
      w_io_win     = io_req & (w_io_starved | ~cpu_req);
      w_io_acc     = reset & w_io_win;
      w_cpu_acc    = reset & cpu_req & ~w_io_win;
   end

   always_comb begin
      dmem_address = '0;
      dmem_data    = '0;
      dmem_wren    = 1'b0;
      if (w_cpu_acc) begin
         dmem_address = cpu_addr;
         dmem_data    = cpu_wdata;
         dmem_wren    = cpu_we;
      end else if (w_io_acc) begin
         dmem_address = io_addr;
         dmem_data    = io_wdata;
         dmem_wren    = io_we;
      end
   end

   always_comb begin
      w_tag_in          = '0;
      w_tag_in[TAG_CPU] = w_cpu_acc & ~cpu_we;
      w_tag_in[TAG_IO]  = w_io_acc & ~io_we;
   end

   // Withdrawal (io_req low) clears the count just like a grant does.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wait_cnt <= '0;
      end else if (io_req & ~w_io_acc) begin
         if (r_wait_cnt != C_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
         end
      end else begin
         r_wait_cnt <= '0;
      end
   end

   rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_tag_pipe (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_tag   (w_tag_in),
      .o_tag   (w_tag_out)
   );

   assign cpu_gnt    = w_cpu_acc;
   assign io_gnt     = w_io_acc;
   assign io_starved = w_io_starved;
   assign cpu_rvalid = w_tag_out[TAG_CPU];
   assign io_rvalid  = w_tag_out[TAG_IO];
   assign cpu_rdata  = dmem_q;
   assign io_rdata   = dmem_q;

endmodule
